// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset pipeline: word width, opcode/funct
// constants, ALU operation codes and the decoded control bundle.
package cpu_pkg;

  localparam int WORD = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_SRAV = 4'd12;

  typedef struct packed {
    logic       is_immd;
    logic       only_shamt;
    logic       mem_w;
    logic       mem_r;
    logic [3:0] alu_op;
    logic       wb_en;
    logic       branch_taken;
    logic       jump_taken;
    logic       terminate;
  } ctrl_t;

endpackage

// File: rtl/control.sv
// ID-stage control: opcode/funct decode, in-ID branch resolution, hazard
// bubble and sticky halt, plus the two operand/index select muxes.
module data_mux
  import cpu_pkg::*;
(
  input  logic            sel,
  input  logic [WORD-1:0] in1,
  input  logic [WORD-1:0] in2,
  output logic [WORD-1:0] out
);
  assign out = sel ? in2 : in1;
endmodule

module reg_mux (
  input  logic       sel,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  output logic [4:0] out
);
  assign out = sel ? in2 : in1;
endmodule

module control
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            harzard,
  input  logic [WORD-1:0] reg_rs_d,
  input  logic [WORD-1:0] reg_rt_d,
  output logic            is_immd,
  output logic            only_shamt,
  output logic            mem_w,
  output logic            mem_r,
  output logic [3:0]      alu_op,
  output logic            wb_en,
  output logic            branch_taken,
  output logic            jump_taken,
  output logic            terminate
);

  ctrl_t dec;
  logic  halted;
  logic  regs_equal;

  assign regs_equal = (reg_rs_d == reg_rt_d);

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        dec.wb_en = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL:  begin dec.alu_op = ALU_SLL; dec.only_shamt = 1'b1; end
          FN_SRL:  begin dec.alu_op = ALU_SRL; dec.only_shamt = 1'b1; end
          FN_SRA:  begin dec.alu_op = ALU_SRA; dec.only_shamt = 1'b1; end
          FN_SLLV: dec.alu_op = ALU_SLLV;
          FN_SRLV: dec.alu_op = ALU_SRLV;
          FN_SRAV: dec.alu_op = ALU_SRAV;
          // Unknown funct degrades to a NOP rather than a stray writeback.
          default: dec = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.is_immd = 1'b1;
        dec.wb_en   = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_op  = ALU_SLT;
        dec.is_immd = 1'b1;
        dec.wb_en   = 1'b1;
      end
      OP_LW: begin
        dec.is_immd = 1'b1;
        dec.mem_r   = 1'b1;
        dec.wb_en   = 1'b1;
      end
      OP_SW: begin
        dec.is_immd = 1'b1;
        dec.mem_w   = 1'b1;
      end
      OP_BEQ:  dec.branch_taken = regs_equal;
      OP_BNE:  dec.branch_taken = ~regs_equal;
      OP_J:    dec.jump_taken   = 1'b1;
      OP_HALT: dec.terminate    = 1'b1;
      default: dec = '0;
    endcase
    // A stall turns the slot into a bubble, including a pending halt.
    if (harzard) dec = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (op == OP_HALT && !harzard)
      halted <= 1'b1;
  end

  assign is_immd      = dec.is_immd;
  assign only_shamt   = dec.only_shamt;
  assign mem_w        = dec.mem_w;
  assign mem_r        = dec.mem_r;
  assign alu_op       = dec.alu_op;
  assign wb_en        = dec.wb_en;
  assign branch_taken = dec.branch_taken;
  assign jump_taken   = dec.jump_taken;
  assign terminate    = dec.terminate | halted;

endmodule

// File: tb/tb_control.sv
// Randomized self-checking bench for control and the ID-stage muxes,
// compared against a table-driven instruction model with a halt bit.
module tb_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        harzard;
  logic [31:0] reg_rs_d, reg_rt_d;
  logic        is_immd, only_shamt, mem_w, mem_r, wb_en;
  logic        branch_taken, jump_taken, terminate;
  logic [3:0]  alu_op;

  logic        dm_sel, rm_sel;
  logic [31:0] dm_in1, dm_in2, dm_out;
  logic [4:0]  rm_in1, rm_in2, rm_out;

  int compared = 0;
  int mismatched = 0;
  bit halted_m;
  int rtype_alu [64];
  bit rtype_shamt [64];
  logic [5:0] op_pool [11];
  logic [5:0] funct_pool [15];

  control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .harzard(harzard),
    .reg_rs_d(reg_rs_d), .reg_rt_d(reg_rt_d),
    .is_immd(is_immd), .only_shamt(only_shamt), .mem_w(mem_w), .mem_r(mem_r),
    .alu_op(alu_op), .wb_en(wb_en), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .terminate(terminate)
  );

  data_mux dm (.sel(dm_sel), .in1(dm_in1), .in2(dm_in2), .out(dm_out));
  reg_mux  rm (.sel(rm_sel), .in1(rm_in1), .in2(rm_in2), .out(rm_out));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected {is_immd, only_shamt, mem_w, mem_r, alu_op, wb_en, branch, jump, term_decode}
  function automatic logic [11:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic hz);
    logic imm = 0, sh = 0, mw = 0, mr = 0, wb = 0, br = 0, jp = 0, tm = 0;
    logic [3:0] aop = 0;
    if (!hz) begin
      if (o == 6'h00) begin
        if (rtype_alu[f] >= 0) begin
          aop = 4'(rtype_alu[f]); wb = 1; sh = rtype_shamt[f];
        end
      end
      else if (o == 6'h08 || o == 6'h09) begin imm = 1; wb = 1; end
      else if (o == 6'h0A) begin imm = 1; wb = 1; aop = 6; end
      else if (o == 6'h23) begin imm = 1; wb = 1; mr = 1; end
      else if (o == 6'h2B) begin imm = 1; mw = 1; end
      else if (o == 6'h04) br = (a == b);
      else if (o == 6'h05) br = (a != b);
      else if (o == 6'h02) jp = 1;
      else if (o == 6'h3F) tm = 1;
    end
    return {imm, sh, mw, mr, aop, wb, br, jp, tm};
  endfunction

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic hz, input logic r);
    logic [11:0] exp;
    @(negedge clk);
    op = o; funct = f; reg_rs_d = a; reg_rt_d = b; harzard = hz; rst = r;
    #1;
    exp = model(o, f, a, b, hz);
    checkOutput("decode",
      {20'd0, is_immd, only_shamt, mem_w, mem_r, alu_op, wb_en, branch_taken, jump_taken},
      {20'd0, exp[11:1]});
    checkOutput("terminate", {31'd0, terminate}, {31'd0, exp[0] | halted_m});
    @(posedge clk);
    if (r) halted_m = 0;
    else if (o == 6'h3F && !hz) halted_m = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin rtype_alu[i] = -1; rtype_shamt[i] = 0; end
    rtype_alu[6'h20] = 0; rtype_alu[6'h21] = 0; rtype_alu[6'h22] = 1; rtype_alu[6'h23] = 1;
    rtype_alu[6'h24] = 2; rtype_alu[6'h25] = 3; rtype_alu[6'h26] = 4; rtype_alu[6'h27] = 5;
    rtype_alu[6'h2A] = 6; rtype_alu[6'h00] = 7; rtype_alu[6'h02] = 8; rtype_alu[6'h03] = 9;
    rtype_alu[6'h04] = 10; rtype_alu[6'h06] = 11; rtype_alu[6'h07] = 12;
    rtype_shamt[6'h00] = 1; rtype_shamt[6'h02] = 1; rtype_shamt[6'h03] = 1;
    op_pool = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h3F, 6'h11};
    funct_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    op = 0; funct = 0; harzard = 0; reg_rs_d = 0; reg_rt_d = 0; rst = 1;
    dm_sel = 0; dm_in1 = 0; dm_in2 = 0; rm_sel = 0; rm_in1 = 0; rm_in2 = 0;
    @(posedge clk);
    halted_m = 0;
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 1);

    applyStimulus(6'h00, 6'h20, 32'h5, 32'h7, 0, 0);
    applyStimulus(6'h00, 6'h00, 32'h5, 32'h7, 0, 0);
    rm_sel = 1; rm_in1 = 5'd9; rm_in2 = 5'd0;
    dm_sel = 1; dm_in1 = 32'hDEAD_BEEF; dm_in2 = 32'h4;
    #1;
    checkOutput("reg_mux_shamt", {27'd0, rm_out}, 32'd0);
    checkOutput("data_mux_shamt", dm_out, 32'h4);
    applyStimulus(6'h23, 6'h00, 32'h1, 32'h2, 0, 0);
    applyStimulus(6'h2B, 6'h00, 32'h1, 32'h2, 0, 0);
    applyStimulus(6'h04, 6'h00, 32'h1234, 32'h1234, 0, 0);
    applyStimulus(6'h04, 6'h00, 32'h1234, 32'h1235, 0, 0);
    applyStimulus(6'h05, 6'h00, 32'h1234, 32'h1234, 0, 0);
    applyStimulus(6'h05, 6'h00, 32'h1234, 32'h1235, 0, 0);
    applyStimulus(6'h23, 6'h00, 32'h1, 32'h2, 1, 0);
    applyStimulus(6'h02, 6'h00, 32'h1, 32'h2, 1, 0);
    applyStimulus(6'h3F, 6'h00, 0, 0, 1, 0);
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 0);
    applyStimulus(6'h3F, 6'h00, 0, 0, 0, 0);
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 0);
    checkOutput("halt_sticky", {31'd0, terminate}, 32'd1);
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 1);
    applyStimulus(6'h00, 6'h00, 0, 0, 0, 0);
    checkOutput("halt_cleared", {31'd0, terminate}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0]  o, f;
      logic [31:0] a, b;
      o = op_pool[$urandom_range(0, 10)];
      if (o == 6'h11) o = 6'($urandom);
      f = ($urandom_range(0, 1) == 0) ? funct_pool[$urandom_range(0, 14)] : 6'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? a : $urandom;
      rm_sel = 1'($urandom); rm_in1 = 5'($urandom); rm_in2 = 5'($urandom);
      dm_sel = 1'($urandom); dm_in1 = $urandom; dm_in2 = $urandom;
      applyStimulus(o, f, a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      checkOutput("reg_mux", {27'd0, rm_out}, {27'd0, rm_sel ? rm_in2 : rm_in1});
      checkOutput("data_mux", dm_out, dm_sel ? dm_in2 : dm_in1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
